// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute bus between the pipeline (master) and the branch predictor (slave).
// ex_valid qualifies every ex_* field for exactly one cycle; there is no back-pressure.
interface branch_predict_ctrl_if;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic        ex_is_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output if_pc, if_instr, ex_valid, ex_pc, ex_instr, ex_is_taken,
             ex_target, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, redirect, redirect_pc
   );

   modport slave (
      input  if_pc, if_instr, ex_valid, ex_pc, ex_instr, ex_is_taken,
             ex_target, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, redirect, redirect_pc
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// BHT-based fetch predictor with same-cycle EX mispredict redirect and
// saturating branch / mispredict performance counters.
module branch_predict_ctrl #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bht_clear,
   branch_predict_ctrl_if.slave  bus,
   output logic                  ready,
   output logic [CNT_W-1:0]      br_count,
   output logic [CNT_W-1:0]      mispred_count,
   output logic                  dbg_state
);

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [6:0]       OP_B    = 7'b1100011;
   localparam logic [6:0]       OP_JAL  = 7'b1101111;
   localparam logic [6:0]       OP_JALR = 7'b1100111;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [1:0]       bht [0:(1<<IDX_W)-1];

   logic [6:0]       if_op;
   logic [IDX_W-1:0] if_idx;
   logic [31:0]      b_imm;
   logic [31:0]      j_imm;
   logic [6:0]       ex_op;
   logic [IDX_W-1:0] ex_idx;
   logic             ctl;
   logic             train;
   logic             unused_bits;

   assign if_op  = bus.if_instr[6:0];
   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign b_imm  = {{20{bus.if_instr[31]}}, bus.if_instr[7], bus.if_instr[30:25],
                    bus.if_instr[11:8], 1'b0};
   assign j_imm  = {{12{bus.if_instr[31]}}, bus.if_instr[19:12], bus.if_instr[20],
                    bus.if_instr[30:21], 1'b0};

   always_comb begin
      bus.pred_taken  = 1'b0;
      bus.pred_target = bus.if_pc + 32'd4;
      if (state == S_RUN) begin
         if (if_op == OP_B) begin
            bus.pred_taken = bht[if_idx][1];
            if (bht[if_idx][1]) bus.pred_target = bus.if_pc + b_imm;
         end else if (if_op == OP_JAL) begin
            bus.pred_taken  = 1'b1;
            bus.pred_target = bus.if_pc + j_imm;
         end
      end
   end

   assign ex_op  = bus.ex_instr[6:0];
   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign ctl    = bus.ex_valid & ((ex_op == OP_B) | (ex_op == OP_JAL) | (ex_op == OP_JALR));
   assign train  = (state == S_RUN) & bus.ex_valid & (ex_op == OP_B);

   // Redirect is evaluated in every state so a branch resolving during a sweep is not lost.
   assign bus.redirect    = ctl & ((bus.ex_is_taken != bus.ex_pred_taken) |
                                   (bus.ex_is_taken & (bus.ex_pred_target != bus.ex_target)));
   assign bus.redirect_pc = bus.ex_is_taken ? bus.ex_target : bus.ex_pc + 32'd4;

   assign unused_bits = ^{bus.ex_instr[31:7], bus.ex_pc[1:0]};
   assign dbg_state   = (state == S_RUN);

   // Table storage needs no reset: the INIT sweep writes every entry before use.
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         bht[idx] <= 2'b01;
      end else if (train) begin
         if (bus.ex_is_taken) begin
            if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
         end else begin
            if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_INIT;
         idx           <= '0;
         ready         <= 1'b0;
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (bht_clear) begin
                  idx <= '0;
               end else if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= S_RUN;
                  ready <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_RUN: begin
               if (bht_clear) begin
                  state <= S_INIT;
                  idx   <= '0;
                  ready <= 1'b0;
               end
               if (ctl && (br_count != '1))
                  br_count <= br_count + CNT_W'(1);
               if (bus.redirect && (mispred_count != '1))
                  mispred_count <= mispred_count + CNT_W'(1);
            end
            default: begin
               state <= S_INIT;
               idx   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: reference BHT/counter model,
// redirect scoreboard queue, INIT sweep timing and counter saturation.
module tb_branch_predict_ctrl;

   logic        clk;
   logic        rst;
   logic        bht_clear;
   logic        ready;
   logic [31:0] br_count;
   logic [31:0] mispred_count;
   logic        dbg_state;
   logic        ready_s;
   logic [3:0]  br_count_s;
   logic [3:0]  mispred_count_s;
   logic        dbg_state_s;

   branch_predict_ctrl_if bus_m ();
   branch_predict_ctrl_if bus_s ();

   branch_predict_ctrl #(.IDX_W(6), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .bht_clear(bht_clear), .bus(bus_m),
      .ready(ready), .br_count(br_count), .mispred_count(mispred_count),
      .dbg_state(dbg_state)
   );

   branch_predict_ctrl #(.IDX_W(6), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .bht_clear(1'b0), .bus(bus_s),
      .ready(ready_s), .br_count(br_count_s), .mispred_count(mispred_count_s),
      .dbg_state(dbg_state_s)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // scoreboard and model state
   int          checks   = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   logic [1:0]  bht_m [64];
   logic        run_m;
   logic [31:0] br_m;
   logic [31:0] mp_m;
   logic        cur_ctl, cur_red, cur_b, cur_t;
   logic [5:0]  cur_idx;

   localparam logic [31:0] JALR_I = 32'h0000_80e7;
   localparam logic [31:0] ADDI_I = 32'h0010_0093;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd1, 5'd2, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   task automatic model_reinit();
      for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
   endtask

   // driver tasks, all entered just after a falling edge
   task automatic ex_drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic t, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
      logic [6:0]  op;
      logic [31:0] rpc;
      op = instr[6:0];
      bus_m.ex_valid       = v;
      bus_m.ex_pc          = pc;
      bus_m.ex_instr       = instr;
      bus_m.ex_is_taken    = t;
      bus_m.ex_target      = tgt;
      bus_m.ex_pred_taken  = pt;
      bus_m.ex_pred_target = ptgt;
      cur_ctl = v && (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111);
      cur_red = cur_ctl && ((t != pt) || (t && (ptgt != tgt)));
      cur_b   = v && (op == 7'b1100011);
      cur_t   = t;
      cur_idx = pc[7:2];
      rpc     = t ? tgt : pc + 32'd4;
      exp_q.push_back({cur_red, rpc});
   endtask

   task automatic ex_finish();
      logic [32:0] e;
      #1;
      e = exp_q.pop_front();
      check("redirect", 32'(bus_m.redirect), 32'(e[32]));
      check("redirect_pc", bus_m.redirect_pc, e[31:0]);
      @(posedge clk);
      if (run_m) begin
         if (cur_b) begin
            if (cur_t) bht_m[cur_idx] = (bht_m[cur_idx] == 2'b11) ? 2'b11 : bht_m[cur_idx] + 2'd1;
            else       bht_m[cur_idx] = (bht_m[cur_idx] == 2'b00) ? 2'b00 : bht_m[cur_idx] - 2'd1;
         end
         if (cur_ctl) br_m = br_m + 32'd1;
         if (cur_red) mp_m = mp_m + 32'd1;
      end
      @(negedge clk);
      bus_m.ex_valid = 1'b0;
   endtask

   task automatic if_check_b(input logic [31:0] pc, input logic [12:0] imm);
      logic tk;
      bus_m.if_pc    = pc;
      bus_m.if_instr = enc_b(imm);
      tk = run_m && bht_m[pc[7:2]][1];
      #1;
      check("pred_taken_b", 32'(bus_m.pred_taken), 32'(tk));
      check("pred_target_b", bus_m.pred_target, tk ? pc + {{19{imm[12]}}, imm} : pc + 32'd4);
   endtask

   task automatic if_check_j(input logic [31:0] pc, input logic [20:0] imm);
      bus_m.if_pc    = pc;
      bus_m.if_instr = enc_j(imm);
      #1;
      check("pred_taken_j", 32'(bus_m.pred_taken), 32'(run_m));
      check("pred_target_j", bus_m.pred_target, run_m ? pc + {{11{imm[20]}}, imm} : pc + 32'd4);
   endtask

   task automatic if_check_other(input logic [31:0] pc, input logic [31:0] instr);
      bus_m.if_pc    = pc;
      bus_m.if_instr = instr;
      #1;
      check("pred_taken_o", 32'(bus_m.pred_taken), 32'd0);
      check("pred_target_o", bus_m.pred_target, pc + 32'd4);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 200) begin
         @(posedge clk);
         n++;
         #1;
      end
      @(negedge clk);
   endtask

   initial begin
      int          n;
      logic [31:0] instr, pc, tgt;
      int          sel;

      rst = 1'b1; bht_clear = 1'b0; run_m = 1'b0; br_m = 0; mp_m = 0;
      bus_m.ex_valid = 1'b0; bus_m.ex_pc = 0; bus_m.ex_instr = 0; bus_m.ex_is_taken = 0;
      bus_m.ex_target = 0; bus_m.ex_pred_taken = 0; bus_m.ex_pred_target = 0;
      bus_m.if_pc = 0; bus_m.if_instr = 0;
      bus_s.ex_valid = 1'b0; bus_s.ex_pc = 0; bus_s.ex_instr = 0; bus_s.ex_is_taken = 0;
      bus_s.ex_target = 0; bus_s.ex_pred_taken = 0; bus_s.ex_pred_target = 0;
      bus_s.if_pc = 0; bus_s.if_instr = 0;
      model_reinit();

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_br_count", br_count, 32'd0);
      check("rst_mispred", mispred_count, 32'd0);
      if_check_j(32'h0000_0500, 21'h0_0100);

      rst = 1'b0;
      wait_ready(n);
      check("init_sweep_len", n, 32'd64);
      run_m = 1'b1;

      for (int i = 0; i < 64; i++) if_check_b(i * 4, 13'h040);
      if_check_j(32'h0000_0020, 21'h1F_FFF0);
      if_check_other(32'h0000_0040, JALR_I);
      if_check_other(32'h0000_0044, ADDI_I);

      // one taken from weakly-not-taken already flips the prediction
      ex_drive(1, 32'h180, enc_b(13'h1FF8), 1, 32'h178, 0, 32'h184);
      ex_finish();
      if_check_b(32'h180, 13'h1FF8);

      // IF reads the pre-write value while EX trains the same entry
      ex_drive(1, 32'h100, enc_b(13'h040), 1, 32'h140, 0, 32'h104);
      if_check_b(32'h100, 13'h040);
      ex_finish();
      ex_drive(1, 32'h100, enc_b(13'h040), 1, 32'h140, 1, 32'h140);
      ex_finish();
      if_check_b(32'h100, 13'h040);
      check("after_two_taken", 32'(bus_m.pred_taken), 32'd1);
      check("after_two_target", bus_m.pred_target, 32'h140);

      ex_drive(1, 32'h300, enc_b(13'h040), 1, 32'h200, 0, 32'h304);
      ex_finish();
      check("mispred_after_beq", mispred_count, mp_m);
      ex_drive(1, 32'h40, JALR_I, 1, 32'h80, 0, 32'h44);
      ex_finish();
      ex_drive(1, 32'h60, enc_j(21'h100), 1, 32'h160, 1, 32'h160);
      ex_finish();
      ex_drive(1, 32'h60, enc_j(21'h100), 1, 32'h160, 1, 32'h164);
      ex_finish();
      ex_drive(1, 32'h100, enc_b(13'h040), 0, 32'h140, 1, 32'h140);
      ex_finish();
      ex_drive(1, 32'h200, enc_b(13'h040), 0, 32'h240, 0, 32'h204);
      ex_finish();
      ex_drive(0, 32'h40, JALR_I, 1, 32'h80, 0, 32'h44);
      ex_finish();
      ex_drive(1, 32'h44, ADDI_I, 1, 32'h80, 0, 32'h48);
      ex_finish();

      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: instr = enc_b(13'($urandom_range(0, 8191)) & 13'h1FFE);
            1: instr = enc_j(21'($urandom_range(0, 2097151)) & 21'h1F_FFFE);
            2: instr = JALR_I;
            default: instr = ADDI_I;
         endcase
         pc  = $urandom & 32'hFFFF_FFFC;
         tgt = $urandom & 32'hFFFF_FFFC;
         ex_drive(1, pc, instr, 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? tgt : tgt ^ 32'h4);
         if_check_b(pc, 13'h020);
         ex_finish();
      end
      check("br_count", br_count, br_m);
      check("mispred_count", mispred_count, mp_m);

      // clear: ready drops on the next edge, full sweep follows, counters kept
      bht_clear = 1'b1;
      @(posedge clk);
      #1;
      check("clear_ready_drop", 32'(ready), 32'd0);
      @(negedge clk);
      bht_clear = 1'b0;
      run_m = 1'b0;
      model_reinit();
      ex_drive(1, 32'h40, JALR_I, 1, 32'h80, 0, 32'h44);
      if_check_j(32'h60, 21'h100);
      ex_finish();
      wait_ready(n);
      check("clear_sweep_len", n + 1, 32'd64);
      run_m = 1'b1;
      check("br_count_kept", br_count, br_m);
      check("mispred_kept", mispred_count, mp_m);
      if_check_b(32'h100, 13'h040);
      check("cleared_not_taken", 32'(bus_m.pred_taken), 32'd0);

      // narrow counters saturate at 15
      check("sat_ready", 32'(ready_s), 32'd1);
      bus_s.ex_valid = 1'b1; bus_s.ex_pc = 32'h40; bus_s.ex_instr = JALR_I;
      bus_s.ex_is_taken = 1'b1; bus_s.ex_target = 32'h80;
      bus_s.ex_pred_taken = 1'b0; bus_s.ex_pred_target = 32'h44;
      repeat (14) @(posedge clk);
      @(negedge clk);
      check("sat_br_14", 32'(br_count_s), 32'd14);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("sat_br_hold", 32'(br_count_s), 32'd15);
      check("sat_mispred_hold", 32'(mispred_count_s), 32'd15);
      bus_s.ex_valid = 1'b0;

      // asynchronous reset takes effect without a clock edge
      rst = 1'b1;
      #1;
      check("async_rst_ready", 32'(ready), 32'd0);
      check("async_rst_br", br_count, 32'd0);
      check("async_rst_mispred", mispred_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
